// File: rtl/rc4_pkg.sv
// Shared types for the RC4 stream core: FSM state encoding, S-box size and byte type.
// The DROP state is only reachable when the core is built with RC4_DROP_EN.
package rc4_pkg;

    localparam int SBOX_SIZE = 256;

    typedef logic [7:0] byte_t;

    typedef enum logic [2:0] {
        IDLE,
        KEY_LOAD,
        S_INIT,
        KSA,
        DROP,
        CRYPT
    } state_e;

endpackage

// File: rtl/rc4_sbox.sv
// RC4 permutation table: 256x8 registers with three combinational read ports,
// a two-entry swap write port and a single-entry init write port (init has priority).
module rc4_sbox
    import rc4_pkg::*;
(
    input  logic  clk,
    input  byte_t rdAddrA_i,
    input  byte_t rdAddrB_i,
    input  byte_t rdAddrC_i,
    output byte_t rdDataA_o,
    output byte_t rdDataB_o,
    output byte_t rdDataC_o,
    input  logic  swapEn_i,
    input  byte_t swapAddrA_i,
    input  byte_t swapDataA_i,
    input  byte_t swapAddrB_i,
    input  byte_t swapDataB_i,
    input  logic  initEn_i,
    input  byte_t initAddr_i,
    input  byte_t initData_i
);

    byte_t mem_q [SBOX_SIZE];

    assign rdDataA_o = mem_q[rdAddrA_i];
    assign rdDataB_o = mem_q[rdAddrB_i];
    assign rdDataC_o = mem_q[rdAddrC_i];

    // When both swap addresses match the two data values are equal, so the entry is unchanged.
    always_ff @(posedge clk) begin
        if (initEn_i) begin
            mem_q[initAddr_i] <= initData_i;
        end else if (swapEn_i) begin
            mem_q[swapAddrA_i] <= swapDataA_i;
            mem_q[swapAddrB_i] <= swapDataB_i;
        end
    end

endmodule

// File: rtl/rc4_stream_core.sv
// RC4 cipher engine: key load, S-box init, KSA, optional keystream drop, then byte-stream XOR.
// Define RC4_DROP_EN to discard the first DROP_N keystream bytes before CRYPT.
module rc4_stream_core
    import rc4_pkg::*;
#(
    parameter int KEY_MAX = 16,
    parameter int KLEN_W  = $clog2(KEY_MAX + 1),
    parameter int DROP_N  = 768
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_in,
    input  logic       key_rvalid,
    input  logic       key_last,
    output logic       key_rready,
    input  logic [7:0] data_in,
    input  logic       data_rvalid,
    input  logic       data_in_last,
    output logic       data_rready,
    output logic [7:0] data_out,
    output logic       data_wvalid,
    output logic       data_out_last,
    input  logic       data_wready,
    output logic       busy
);

    localparam int KIDX_W = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;

    state_e             state_q, state_d;
    byte_t              i_q, i_d, j_q, j_d;
    logic [KLEN_W-1:0]  keyLen_q, keyLen_d, keyIdx_q, keyIdx_d;
    byte_t              dataOut_q, dataOut_d;
    logic               wvalid_q, wvalid_d, outLast_q, outLast_d, lastSeen_q, lastSeen_d;

    byte_t              key_q [KEY_MAX];
    logic               keyWrEn;
    logic [KIDX_W-1:0]  keyWrAddr;

    byte_t iNext, jNext, rdAddrA, tIdx, keyByte, keystream;
    byte_t sA, sB, sC;
    logic  swapEn, keyFire, dataFire, outFire;

`ifdef RC4_DROP_EN
    localparam int DCNT_W = (DROP_N > 1) ? $clog2(DROP_N + 1) : 1;
    logic [DCNT_W-1:0] dropCnt_q, dropCnt_d;
`else
    logic unusedDropN;
    assign unusedDropN = (DROP_N != 0);
`endif

    // KSA indexes S[i]; PRGA steps (DROP/CRYPT) pre-increment i. The key byte only enters during KSA.
    assign iNext     = i_q + 8'd1;
    assign rdAddrA   = (state_q == KSA) ? i_q : iNext;
    assign keyByte   = key_q[keyIdx_q[KIDX_W-1:0]];
    assign jNext     = j_q + sA + ((state_q == KSA) ? keyByte : 8'd0);
    assign tIdx      = sA + sB;
    assign keystream = (tIdx == iNext) ? sB : ((tIdx == jNext) ? sA : sC);

    assign key_rready  = (state_q == IDLE) || (state_q == KEY_LOAD);
    assign data_rready = (state_q == CRYPT) && !lastSeen_q && (!wvalid_q || data_wready);
    assign keyFire     = key_rvalid && key_rready;
    assign dataFire    = data_rvalid && data_rready;
    assign outFire     = wvalid_q && data_wready;

    rc4_sbox u_sbox (
        .clk         (clk),
        .rdAddrA_i   (rdAddrA),
        .rdAddrB_i   (jNext),
        .rdAddrC_i   (tIdx),
        .rdDataA_o   (sA),
        .rdDataB_o   (sB),
        .rdDataC_o   (sC),
        .swapEn_i    (swapEn),
        .swapAddrA_i (rdAddrA),
        .swapDataA_i (sB),
        .swapAddrB_i (jNext),
        .swapDataB_i (sA),
        .initEn_i    (state_q == S_INIT),
        .initAddr_i  (i_q),
        .initData_i  (i_q)
    );

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        j_d        = j_q;
        keyLen_d   = keyLen_q;
        keyIdx_d   = keyIdx_q;
        dataOut_d  = dataOut_q;
        wvalid_d   = wvalid_q;
        outLast_d  = outLast_q;
        lastSeen_d = lastSeen_q;
        keyWrEn    = 1'b0;
        keyWrAddr  = '0;
        swapEn     = 1'b0;
`ifdef RC4_DROP_EN
        dropCnt_d  = dropCnt_q;
`endif
        case (state_q)
            IDLE: begin
                i_d      = '0;
                j_d      = '0;
                keyIdx_d = '0;
                if (keyFire) begin
                    keyWrEn  = 1'b1;
                    keyLen_d = KLEN_W'(1);
                    state_d  = key_last ? S_INIT : KEY_LOAD;
                end
            end
            KEY_LOAD: begin
                if (keyFire) begin
                    // Bytes past KEY_MAX are handshaken but dropped; key_len saturates.
                    if (keyLen_q < KLEN_W'(KEY_MAX)) begin
                        keyWrEn   = 1'b1;
                        keyWrAddr = keyLen_q[KIDX_W-1:0];
                        keyLen_d  = keyLen_q + KLEN_W'(1);
                    end
                    if (key_last) begin
                        state_d = S_INIT;
                    end
                end
            end
            S_INIT: begin
                i_d = iNext;
                if (i_q == 8'hFF) begin
                    state_d = KSA;
                end
            end
            KSA: begin
                swapEn   = 1'b1;
                i_d      = iNext;
                j_d      = jNext;
                keyIdx_d = (keyIdx_q + KLEN_W'(1) == keyLen_q) ? '0 : keyIdx_q + KLEN_W'(1);
                if (i_q == 8'hFF) begin
                    j_d = '0;
`ifdef RC4_DROP_EN
                    dropCnt_d = '0;
                    state_d   = (DROP_N == 0) ? CRYPT : DROP;
`else
                    state_d   = CRYPT;
`endif
                end
            end
`ifdef RC4_DROP_EN
            DROP: begin
                swapEn    = 1'b1;
                i_d       = iNext;
                j_d       = jNext;
                dropCnt_d = dropCnt_q + DCNT_W'(1);
                if (dropCnt_q == DCNT_W'(DROP_N - 1)) begin
                    state_d = CRYPT;
                end
            end
`endif
            CRYPT: begin
                if (outFire) begin
                    wvalid_d = 1'b0;
                    if (outLast_q) begin
                        outLast_d  = 1'b0;
                        lastSeen_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
                if (dataFire) begin
                    swapEn     = 1'b1;
                    i_d        = iNext;
                    j_d        = jNext;
                    dataOut_d  = data_in ^ keystream;
                    wvalid_d   = 1'b1;
                    outLast_d  = data_in_last;
                    lastSeen_d = data_in_last;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            keyLen_q   <= '0;
            keyIdx_q   <= '0;
            dataOut_q  <= '0;
            wvalid_q   <= 1'b0;
            outLast_q  <= 1'b0;
            lastSeen_q <= 1'b0;
`ifdef RC4_DROP_EN
            dropCnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            j_q        <= j_d;
            keyLen_q   <= keyLen_d;
            keyIdx_q   <= keyIdx_d;
            dataOut_q  <= dataOut_d;
            wvalid_q   <= wvalid_d;
            outLast_q  <= outLast_d;
            lastSeen_q <= lastSeen_d;
`ifdef RC4_DROP_EN
            dropCnt_q  <= dropCnt_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (keyWrEn) begin
            key_q[keyWrAddr] <= key_in;
        end
    end

    assign data_out      = dataOut_q;
    assign data_wvalid   = wvalid_q;
    assign data_out_last = outLast_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_rc4_stream_core.sv
// Self-checking bench for rc4_stream_core: known-answer table plus backpressure,
// long-key, reset-abort and ready-timing sequences. Honours RC4_DROP_EN (DROP_N=4).
module tb_rc4_stream_core;

`ifdef RC4_DROP_EN
    localparam int TB_DROP = 4;
`else
    localparam int TB_DROP = 0;
`endif
    localparam int KEY_MAX = 16;

    typedef struct {
        string        key;
        string        pt;
        logic [127:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_in;
    logic       key_rvalid, key_last, key_rready;
    logic [7:0] data_in;
    logic       data_rvalid, data_in_last, data_rready;
    logic [7:0] data_out;
    logic       data_wvalid, data_out_last, data_wready, busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] keyBuf [0:31];
    int         keyLen;
    logic [7:0] msgBuf [0:63];
    logic [7:0] expBuf [0:63];
    logic [7:0] ksBuf  [0:63];
    int         msgLen;

    vec_t vecs [3];
    int   numVecs;

    always #5 clk = ~clk;

    rc4_stream_core #(.KEY_MAX(KEY_MAX), .DROP_N(TB_DROP)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .key_rvalid    (key_rvalid),
        .key_last      (key_last),
        .key_rready    (key_rready),
        .data_in       (data_in),
        .data_rvalid   (data_rvalid),
        .data_in_last  (data_in_last),
        .data_rready   (data_rready),
        .data_out      (data_out),
        .data_wvalid   (data_wvalid),
        .data_out_last (data_out_last),
        .data_wready   (data_wready),
        .busy          (busy)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic loadKey(input string k);
        keyLen = k.len();
        for (int n = 0; n < keyLen; n++) keyBuf[n] = k[n];
    endtask

    task automatic loadMsg(input string m);
        msgLen = m.len();
        for (int n = 0; n < msgLen; n++) msgBuf[n] = m[n];
    endtask

    // Textbook RC4 reference: KSA over the first kl key bytes, TB_DROP discarded bytes, then n bytes.
    task automatic refModel(input int kl, input int n);
        int s [0:255];
        int a, b, tmp, t;
        for (int x = 0; x < 256; x++) s[x] = x;
        b = 0;
        for (int x = 0; x < 256; x++) begin
            b = (b + s[x] + int'(keyBuf[x % kl])) & 255;
            tmp = s[x]; s[x] = s[b]; s[b] = tmp;
        end
        a = 0;
        b = 0;
        for (int d = 0; d < TB_DROP + n; d++) begin
            a = (a + 1) & 255;
            b = (b + s[a]) & 255;
            tmp = s[a]; s[a] = s[b]; s[b] = tmp;
            t = (s[a] + s[b]) & 255;
            if (d >= TB_DROP) ksBuf[d - TB_DROP] = 8'(s[t]);
        end
        for (int x = 0; x < n; x++) expBuf[x] = msgBuf[x] ^ ksBuf[x];
    endtask

    // Called just after a negedge; returns just after the negedge following the last key handshake.
    task automatic sendKey();
        for (int k = 0; k < keyLen; k++) begin
            key_in     = keyBuf[k];
            key_rvalid = 1'b1;
            key_last   = (k == keyLen - 1);
            #1;
            checkOutput($sformatf("key_rready byte %0d", k), 32'(key_rready), 32'd1);
            @(posedge clk);
            @(negedge clk);
        end
        key_rvalid = 1'b0;
        key_last   = 1'b0;
    endtask

    task automatic applyStimulus(input string name, input bit randReady);
        int         inIdx   = 0;
        int         outIdx  = 0;
        int         cyc     = 0;
        logic       stalled = 1'b0;
        logic       inAcc;
        logic [7:0] heldByte = '0;
        logic       heldLast = 1'b0;
        while (outIdx < msgLen && cyc < 3000) begin
            data_wready  = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            data_rvalid  = (inIdx < msgLen);
            data_in      = (inIdx < msgLen) ? msgBuf[inIdx] : 8'h00;
            data_in_last = (inIdx == msgLen - 1);
            #1;
            if (stalled) begin
                checkOutput($sformatf("%s stall hold", name),
                            {22'd0, data_wvalid, data_out_last, data_out}, {22'd0, 1'b1, heldLast, heldByte});
            end
            if (data_wvalid && data_wready) begin
                checkOutput($sformatf("%s byte %0d", name, outIdx), 32'(data_out), 32'(expBuf[outIdx]));
                checkOutput($sformatf("%s last %0d", name, outIdx), 32'(data_out_last), 32'(outIdx == msgLen - 1));
                outIdx++;
            end
            stalled  = data_wvalid && !data_wready;
            heldByte = data_out;
            heldLast = data_out_last;
            inAcc    = data_rvalid && data_rready;
            @(posedge clk);
            @(negedge clk);
            if (inAcc) inIdx++;
            cyc++;
        end
        if (outIdx < msgLen) checkOutput($sformatf("%s timeout outputs", name), 32'(outIdx), 32'(msgLen));
        data_rvalid  = 1'b0;
        data_in_last = 1'b0;
        data_wready  = 1'b1;
        #1;
        checkOutput($sformatf("%s busy after", name), 32'(busy), 32'd0);
        checkOutput($sformatf("%s wvalid after", name), 32'(data_wvalid), 32'd0);
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, " key_rready"}, 32'(key_rready), 32'd1);
        checkOutput({name, " data_rready"}, 32'(data_rready), 32'd0);
        checkOutput({name, " data_wvalid"}, 32'(data_wvalid), 32'd0);
        checkOutput({name, " data_out"}, 32'(data_out), 32'd0);
        checkOutput({name, " data_out_last"}, 32'(data_out_last), 32'd0);
        checkOutput({name, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int edges;

`ifdef RC4_DROP_EN
        // Keystream for "Key" after dropping 4 bytes: B7 34 CA 72 A7; "Plain" XOR that.
        vecs[0].key = "Key";  vecs[0].pt = "Plain";  vecs[0].exp = 128'hE758AB1BC9;
        numVecs = 1;
`else
        vecs[0].key = "Key";    vecs[0].pt = "Plaintext";      vecs[0].exp = 128'hBBF316E8D940AF0AD3;
        vecs[1].key = "Wiki";   vecs[1].pt = "pedia";          vecs[1].exp = 128'h1021BF0420;
        vecs[2].key = "Secret"; vecs[2].pt = "Attack at dawn"; vecs[2].exp = 128'h45A01F645FC35B383552544B9BF5;
        numVecs = 3;
`endif

        rst          = 1'b0;
        key_in       = '0;
        key_rvalid   = 1'b0;
        key_last     = 1'b0;
        data_in      = "p";
        data_rvalid  = 1'b1;
        data_in_last = 1'b0;
        data_wready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checkResetState("reset");
        rst = 1'b1;

        // data_rvalid held since reset: data_rready must stay low until CRYPT.
        @(negedge clk);
        loadKey("Wiki");
        sendKey();
        #1;
        checkOutput("key_rready after last", 32'(key_rready), 32'd0);
        checkOutput("busy after key", 32'(busy), 32'd1);
        edges = 0;
        while (!data_rready && edges < 2000) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            edges++;
        end
        checkOutput("edges to data_rready", 32'(edges), 32'(512 + TB_DROP));
        loadMsg("pedia");
        refModel(keyLen, msgLen);
        applyStimulus("wiki_hold", 1'b0);

        for (int v = 0; v < numVecs; v++) begin
            loadKey(vecs[v].key);
            loadMsg(vecs[v].pt);
            for (int k = 0; k < msgLen; k++) expBuf[k] = vecs[v].exp[8*(msgLen-1-k) +: 8];
            @(negedge clk);
            sendKey();
            applyStimulus($sformatf("vec%0d", v), 1'b0);
        end

        // Same first vector with random downstream backpressure.
        loadKey(vecs[0].key);
        loadMsg(vecs[0].pt);
        for (int k = 0; k < msgLen; k++) expBuf[k] = vecs[0].exp[8*(msgLen-1-k) +: 8];
        @(negedge clk);
        sendKey();
        applyStimulus("backpressure", 1'b1);

        // KEY_MAX+4 key bytes: the tail is accepted but must not affect the keystream.
        keyLen = KEY_MAX + 4;
        for (int k = 0; k < keyLen; k++) keyBuf[k] = 8'((k * 37 + 5) & 255);
        loadMsg("LongKeyCheck");
        refModel(KEY_MAX, msgLen);
        @(negedge clk);
        sendKey();
        applyStimulus("longkey", 1'b0);

        // Reset part-way through KSA, then a fresh key must produce correct output.
        loadKey("Key");
        @(negedge clk);
        sendKey();
        repeat (300) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        checkResetState("ksa_reset");
        rst = 1'b1;
        loadKey("Wiki");
        loadMsg("pedia");
        refModel(keyLen, msgLen);
        @(negedge clk);
        sendKey();
        applyStimulus("after_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
